// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: recovers the duty cycle of an asynchronous PWM stream.
// Measures the carrier period and the high time between consecutive rising
// edges and turns each pair into an 8-bit sample floor(256*high/period)
// with an 8-step restoring divider. If no rising edge is seen for TIMEOUT
// clocks, it reports a stuck-high or stuck-low level instead.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for an armed rise; watches for the timeout
// ST_DIV  | 8 restoring-divide iterations, one quotient bit per clock
// ST_DONE | sample published this cycle (valid_o high), back to idle
module pwm_duty_meter #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic             clk_100m,
    input  logic             rst_n,
    input  logic             pwm_i,
    output logic [7:0]       duty_o,
    output logic [CNT_W-1:0] period_o,
    output logic             valid_o,
    output logic             stuck_o
);

    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Synchroniser and edge detect
    logic sync1_q;
    logic pwm_s_q;
    logic pwm_d_q;
    logic rise;

    // Measurement counters
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q,  hi_cnt_d;

    // Control flags
    logic armed_q,    armed_d;
    logic tmo_done_q, tmo_done_d;
    logic tmo_hit;

    // Divider datapath; the remainder is one bit wider than the divisor so
    // the doubled remainder never overflows before the compare.
    logic [CNT_W:0]   rem_q, rem_d;
    logic [CNT_W:0]   rem_shl;
    logic [CNT_W:0]   rem_sub;
    logic             take;
    logic [CNT_W-1:0] div_q, div_d;
    logic [7:0]       quo_q, quo_d;
    logic [2:0]       iter_q, iter_d;

    // Published results
    logic [7:0]       duty_q,   duty_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q,  valid_d;
    logic             stuck_q,  stuck_d;

    // Two-flop synchroniser plus one delayed copy for rising-edge detection
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            pwm_s_q <= 1'b0;
            pwm_d_q <= 1'b0;
        end else begin
            sync1_q <= pwm_i;
            pwm_s_q <= sync1_q;
            pwm_d_q <= pwm_s_q;
        end
    end

    assign rise = pwm_s_q & ~pwm_d_q;

    // Period / high-time counters; a rise restarts both at 1 so the rise
    // cycle belongs to the new interval. Both saturate at TIMEOUT.
    always_comb begin
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        if (rise) begin
            per_cnt_d = CNT_ONE;
            hi_cnt_d  = CNT_ONE;
        end else begin
            if (per_cnt_q != TMO) begin
                per_cnt_d = per_cnt_q + CNT_ONE;
            end
            if (pwm_s_q && (hi_cnt_q != TMO)) begin
                hi_cnt_d = hi_cnt_q + CNT_ONE;
            end
        end
    end

    // Timeout fires once per stall, only while the divider is idle
    assign tmo_hit = (state_q == ST_IDLE) && (per_cnt_q == TMO) && !tmo_done_q;

    // One restoring-divide step: double the remainder, subtract if it fits
    assign rem_shl = rem_q << 1;
    assign rem_sub = rem_shl - {1'b0, div_q};
    assign take    = (rem_shl >= {1'b0, div_q});

    // FSM next-state, divider and result-register updates
    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        tmo_done_d = tmo_done_q;
        rem_d      = rem_q;
        div_d      = div_q;
        quo_d      = quo_q;
        iter_d     = iter_q;
        duty_d     = duty_q;
        period_d   = period_q;
        stuck_d    = stuck_q;
        valid_d    = 1'b0;

        if (tmo_hit) begin
            armed_d    = 1'b0;
            tmo_done_d = 1'b1;
            duty_d     = pwm_s_q ? 8'hFF : 8'h00;
            period_d   = '0;
            stuck_d    = 1'b1;
            valid_d    = 1'b1;
        end

        // A rise always re-arms and re-enables the timeout, even when it
        // coincides with the timeout itself; that rise yields no sample.
        if (rise) begin
            armed_d    = 1'b1;
            tmo_done_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (rise && armed_q && !tmo_hit) begin
                    state_d = ST_DIV;
                    rem_d   = {1'b0, hi_cnt_q};
                    div_d   = per_cnt_q;
                    quo_d   = 8'h00;
                    iter_d  = 3'd0;
                end
            end
            ST_DIV: begin
                rem_d  = take ? rem_sub : rem_shl;
                quo_d  = {quo_q[6:0], take};
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    // Results land with the move to DONE so valid_o and the
                    // new values appear in the same cycle.
                    state_d  = ST_DONE;
                    duty_d   = {quo_q[6:0], take};
                    period_d = div_q;
                    stuck_d  = 1'b0;
                    valid_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters, divider and result registers
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            per_cnt_q  <= '0;
            hi_cnt_q   <= '0;
            armed_q    <= 1'b0;
            tmo_done_q <= 1'b0;
            rem_q      <= '0;
            div_q      <= '0;
            quo_q      <= 8'h00;
            iter_q     <= 3'd0;
            duty_q     <= 8'h00;
            period_q   <= '0;
            valid_q    <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            per_cnt_q  <= per_cnt_d;
            hi_cnt_q   <= hi_cnt_d;
            armed_q    <= armed_d;
            tmo_done_q <= tmo_done_d;
            rem_q      <= rem_d;
            div_q      <= div_d;
            quo_q      <= quo_d;
            iter_q     <= iter_d;
            duty_q     <= duty_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            stuck_q    <= stuck_d;
        end
    end

    assign duty_o   = duty_q;
    assign period_o = period_q;
    assign valid_o  = valid_q;
    assign stuck_o  = stuck_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Bench for pwm_duty_meter: directed scenarios plus randomized PWM traffic,
// checked every cycle against an event-level model of the measurement rules.
module tb_pwm_duty_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1000;

    logic             clk_100m = 1'b0;
    logic             rst_n;
    logic             pwm_i;
    logic [7:0]       duty_o;
    logic [CNT_W-1:0] period_o;
    logic             valid_o;
    logic             stuck_o;

    pwm_duty_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_100m (clk_100m),
        .rst_n    (rst_n),
        .pwm_i    (pwm_i),
        .duty_o   (duty_o),
        .period_o (period_o),
        .valid_o  (valid_o),
        .stuck_o  (stuck_o)
    );

    always #5 clk_100m = ~clk_100m;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int   cyc;
        int   duty;
        int   per;
        logic stuck;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    bit   in_rst   = 1;
    bit   p1 = 0, p2 = 0;     // pwm_i seen one and two cycles ago
    bit   s_prev   = 0;
    int   last     = 0;       // cycle of the last rise (or reset release)
    int   hi_acc   = 0;       // synchronised-high cycles since last
    int   free_at  = 0;       // first cycle the divider can accept a rise
    bit   armed    = 0;
    bit   to_done  = 0;
    int   e_duty   = 0;
    int   e_per    = 0;
    bit   e_stuck  = 0;
    int   valid_cnt = 0;
    int   last_valid_cyc = -100;
    bit   fast_mode = 0;
    int   gap_err  = 0;

    // Model step and per-cycle comparison, 2 time units after each edge
    always @(posedge clk_100m) begin
        #2;
        cyc++;
        if (valid_o === 1'b1) begin
            valid_cnt++;
            if (fast_mode && (cyc - last_valid_cyc) < 12) gap_err++;
            last_valid_cyc = cyc;
        end
        if (!rst_n) begin
            in_rst = 1; p1 = 0; p2 = 0; s_prev = 0; hi_acc = 0;
            free_at = 0; armed = 0; to_done = 0;
            exp_q.delete();
            e_duty = 0; e_per = 0; e_stuck = 0;
            check("rst_valid", valid_o, 0);
            check("rst_duty", duty_o, 0);
            check("rst_period", period_o, 0);
            check("rst_stuck", stuck_o, 0);
        end else begin
            bit   s, rise, fire, idle, exp_v;
            int   pc;
            exp_t e;
            if (in_rst) begin
                in_rst = 0;
                last   = cyc;
            end
            s    = p2;
            rise = s && !s_prev;
            pc   = (cyc - last > TIMEOUT) ? TIMEOUT : cyc - last;
            idle = (cyc >= free_at);
            fire = idle && (pc == TIMEOUT) && !to_done;
            if (fire) begin
                e.cyc = cyc + 1; e.duty = s ? 255 : 0; e.per = 0; e.stuck = 1;
                exp_q.push_back(e);
                armed   = 0;
                to_done = 1;
            end
            if (rise) begin
                if (armed && idle && !fire) begin
                    e.cyc = cyc + 9; e.per = cyc - last;
                    e.duty = (256 * hi_acc) / e.per; e.stuck = 0;
                    exp_q.push_back(e);
                    free_at = cyc + 10;
                end
                last    = cyc;
                hi_acc  = 0;
                armed   = 1;
                to_done = 0;
            end
            hi_acc += int'(s);
            s_prev = s;
            p2 = p1;
            p1 = pwm_i;

            exp_v = 0;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                exp_v = 1; e_duty = e.duty; e_per = e.per; e_stuck = e.stuck;
            end
            if (valid_o !== exp_v)
                $display("FAIL valid cyc=%0d actual=%0b expected=%0b", cyc, valid_o, exp_v);
            check("valid", valid_o, exp_v);
            check("duty", duty_o, e_duty);
            check("period", period_o, e_per);
            check("stuck", stuck_o, e_stuck);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit lvl, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_100m);
            #1 pwm_i = lvl;
        end
    endtask

    task automatic run_pwm(input int period, input int high, input int reps);
        for (int r = 0; r < reps; r++) begin
            drive(1'b1, high);
            drive(1'b0, period - high);
        end
    endtask

    int v0;

    initial begin
        rst_n = 1'b0;
        pwm_i = 1'b0;

        // Reset held for 4 clocks while the input toggles
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_100m);
            #1 pwm_i = ~pwm_i;
        end
        check("reset_no_valid", valid_cnt, 0);
        @(posedge clk_100m);
        #1 rst_n = 1'b1;
        pwm_i = 1'b0;

        // 256/64: first rise only arms, the next three rises measure
        v0 = valid_cnt;
        run_pwm(256, 64, 4);
        drive(1'b0, 20);
        check("p256_count", valid_cnt - v0, 3);
        check("p256_duty", duty_o, 64);
        check("p256_period", period_o, 256);
        check("p256_stuck", stuck_o, 0);
        check("p256_model", e_duty, 64);

        run_pwm(200, 100, 3);
        drive(1'b0, 20);
        check("p200_duty", duty_o, 128);
        check("p200_period", period_o, 200);
        check("p200_model", e_duty, 128);

        run_pwm(300, 1, 3);
        drive(1'b0, 20);
        check("p300h1_duty", duty_o, 0);
        check("p300h1_period", period_o, 300);

        run_pwm(300, 299, 3);
        drive(1'b0, 20);
        check("p300h299_duty", duty_o, 255);
        check("p300h299_model", e_duty, 255);

        // Fast carrier: at most one sample per 12 clocks, all 50%
        fast_mode = 1;
        v0 = valid_cnt;
        run_pwm(6, 3, 20);
        drive(1'b0, 20);
        fast_mode = 0;
        check("fast_gap", gap_err, 0);
        check("fast_duty", duty_o, 128);
        check("fast_count", (valid_cnt - v0 >= 5) ? 1 : 0, 1);

        // Reset while the divider is busy: no sample comes out
        drive(1'b1, 5);
        v0 = valid_cnt;
        @(posedge clk_100m);
        #1 rst_n = 1'b0;
        drive(1'b1, 3);
        @(posedge clk_100m);
        #1 rst_n = 1'b1;
        pwm_i = 1'b0;
        drive(1'b0, 30);
        check("middiv_no_valid", valid_cnt - v0, 0);
        check("middiv_duty", duty_o, 0);

        // Stuck low: exactly one timeout report
        v0 = valid_cnt;
        drive(1'b0, 1200);
        check("stuck_lo_count", valid_cnt - v0, 1);
        check("stuck_lo_duty", duty_o, 0);
        check("stuck_lo_flag", stuck_o, 1);
        check("stuck_lo_period", period_o, 0);

        run_pwm(256, 128, 3);
        drive(1'b0, 20);
        check("rearm_duty", duty_o, 128);
        check("rearm_flag", stuck_o, 0);

        // Stuck high: reported as 255
        drive(1'b1, 1200);
        check("stuck_hi_duty", duty_o, 255);
        check("stuck_hi_flag", stuck_o, 1);
        drive(1'b0, 20);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            int sel, per, hi, reps;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                drive(1'($urandom_range(0, 1)), $urandom_range(1001, 1400));
            end else begin
                per  = (sel == 1) ? $urandom_range(2, 12) : $urandom_range(10, 500);
                hi   = $urandom_range(1, per - 1);
                reps = $urandom_range(1, 4);
                run_pwm(per, hi, reps);
            end
        end
        drive(1'b0, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
